// File: rtl/condicionador_botoes_if.sv
// Button conditioner bus: raw levels and enable in, pulses/levels/count out.
// master = consumer/driver side, slave = condicionador_botoes.
interface condicionador_botoes_if #(
    parameter int N_BOTOES = 8
);
    logic                habilita;
    logic [N_BOTOES-1:0] botoes_raw;
    logic [N_BOTOES-1:0] botoes_pulso;
    logic [N_BOTOES-1:0] botoes_estavel;
    logic [7:0]          contador_jogadas;

    modport master (
        output habilita,
        output botoes_raw,
        input  botoes_pulso,
        input  botoes_estavel,
        input  contador_jogadas
    );

    modport slave (
        input  habilita,
        input  botoes_raw,
        output botoes_pulso,
        output botoes_estavel,
        output contador_jogadas
    );
endinterface

// File: rtl/condicionador_botoes.sv
// Sync, debounce and edge-detect push-buttons; issue one-hot press pulses.
// Optional move counter: define CONDICIONADOR_CONTADOR_JOGADAS_EN.
module condicionador_botoes #(
    parameter int N_BOTOES        = 8,
    parameter int DEBOUNCE_CICLOS = 50000,
    parameter int SYNC_STAGES     = 2
) (
    input logic                   clk,
    input logic                   rst_n,
    condicionador_botoes_if.slave bus
);
    localparam int CW = $clog2(DEBOUNCE_CICLOS);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS - 1);

    logic [SYNC_STAGES-1:0][N_BOTOES-1:0] sync_q;
    logic [N_BOTOES-1:0]                  sync_w;
    logic [N_BOTOES-1:0][CW-1:0]          cnt_q;
    logic [N_BOTOES-1:0][CW-1:0]          cnt_d;
    logic [N_BOTOES-1:0]                  estavel_q;
    logic [N_BOTOES-1:0]                  estavel_d;
    logic [N_BOTOES-1:0]                  subida;
    logic [N_BOTOES-1:0]                  pendente_q;
    logic [N_BOTOES-1:0]                  pendente_d;
    logic [N_BOTOES-1:0]                  grant;
    logic [N_BOTOES-1:0]                  pulso_q;
    logic [N_BOTOES-1:0]                  pulso_d;

    assign sync_w = sync_q[SYNC_STAGES-1];

    // Synchroniser chain for the asynchronous raw levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= bus.botoes_raw;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // Per-bit debounce; a rise is flagged on the edge the new level is accepted.
    always_comb begin
        cnt_d     = cnt_q;
        estavel_d = estavel_q;
        subida    = '0;
        for (int i = 0; i < N_BOTOES; i++) begin
            if (sync_w[i] == estavel_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                estavel_d[i] = sync_w[i];
                cnt_d[i]     = '0;
                subida[i]    = sync_w[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    // Lowest-index pending bit wins; a same-edge new rise keeps its bit pending.
    always_comb begin
        grant      = pendente_q & (~pendente_q + N_BOTOES'(1));
        pulso_d    = '0;
        pendente_d = '0;
        if (bus.habilita) begin
            pulso_d    = grant;
            pendente_d = (pendente_q & ~grant) | subida;
        end
    end

    // Debounce, pending mask and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            estavel_q  <= '0;
            pendente_q <= '0;
            pulso_q    <= '0;
        end else begin
            cnt_q      <= cnt_d;
            estavel_q  <= estavel_d;
            pendente_q <= pendente_d;
            pulso_q    <= pulso_d;
        end
    end

    assign bus.botoes_pulso   = pulso_q;
    assign bus.botoes_estavel = estavel_q;

`ifdef CONDICIONADOR_CONTADOR_JOGADAS_EN
    logic [7:0] jogadas_q;
    logic [7:0] jogadas_d;

    // Saturating count of issued pulses.
    always_comb begin
        jogadas_d = jogadas_q;
        if ((|pulso_d) && (jogadas_q != 8'hFF)) begin
            jogadas_d = jogadas_q + 8'd1;
        end
    end

    // Move counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jogadas_q <= '0;
        end else begin
            jogadas_q <= jogadas_d;
        end
    end

    assign bus.contador_jogadas = jogadas_q;
`else
    assign bus.contador_jogadas = 8'd0;
`endif
endmodule
